// File: rtl/mem_lane_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_unit_if
//  Brief    : Data-bus bundle between the MEM-stage access unit and memory.
//             The unit drives a single request/acknowledge transaction.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_lane_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_unit
//  Brief    : MEM-stage data access unit. Places store data into byte lanes
//             with byte enables, extracts and extends load data, and runs one
//             request/acknowledge bus transaction per access.
//  Revision : 1.0  initial release
// ============================================================================
module mem_lane_unit (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        start,
   input  wire logic [2:0]  op,
   input  wire logic [31:0] addr,
   input  wire logic [31:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [31:0]      rdata,
   output logic             addr_err,
   mem_lane_unit_if.master  bus
);

   localparam logic [2:0] c_op_lw  = 3'b000;
   localparam logic [2:0] c_op_lh  = 3'b001;
   localparam logic [2:0] c_op_lhu = 3'b010;
   localparam logic [2:0] c_op_lb  = 3'b011;
   localparam logic [2:0] c_op_lbu = 3'b100;
   localparam logic [2:0] c_op_sw  = 3'b101;
   localparam logic [2:0] c_op_sh  = 3'b110;
   localparam logic [2:0] c_op_sb  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [2:0]  r_op;
   logic [1:0]  r_off;
   logic        r_we;
   logic [29:0] r_word;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_addr_err;

   logic        w_misaligned;
   logic        w_is_store;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   // Alignment check, lane enables and lane-replicated data for the incoming request
   always_comb begin
      w_misaligned = 1'b0;
      w_is_store   = 1'b0;
      w_be         = 4'b1111;
      w_wdata      = wdata;
      case (op)
         c_op_lw:           w_misaligned = (addr[1:0] != 2'b00);
         c_op_lh, c_op_lhu: w_misaligned = addr[0];
         c_op_sw: begin
            w_misaligned = (addr[1:0] != 2'b00);
            w_is_store   = 1'b1;
         end
         c_op_sh: begin
            w_misaligned = addr[0];
            w_is_store   = 1'b1;
            w_be         = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata      = {wdata[15:0], wdata[15:0]};
         end
         c_op_sb: begin
            w_is_store   = 1'b1;
            w_be         = 4'b0001 << addr[1:0];
            w_wdata      = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // Pick the addressed lane out of the returned word and extend it
   always_comb begin
      w_byte = bus.bus_rdata[8*r_off +: 8];
      w_half = r_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (r_op)
         c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
         c_op_lhu: w_load = {16'h0000, w_half};
         c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
         c_op_lbu: w_load = {24'h000000, w_byte};
         default:  w_load = bus.bus_rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state: misaligned requests skip the bus entirely
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next_state = w_misaligned ? ST_DONE : ST_REQ;
         ST_REQ:  if (bus.bus_ack) w_next_state = ST_DONE;
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Capture the request on acceptance and the load result on acknowledge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op       <= 3'b000;
         r_off      <= 2'b00;
         r_we       <= 1'b0;
         r_word     <= 30'd0;
         r_be       <= 4'b0000;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_addr_err <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         if (w_misaligned) begin
            r_addr_err <= 1'b1;
            r_rdata    <= 32'd0;
         end else begin
            r_addr_err <= 1'b0;
            r_op       <= op;
            r_off      <= addr[1:0];
            r_we       <= w_is_store;
            r_word     <= addr[31:2];
            r_be       <= w_be;
            r_wdata    <= w_wdata;
         end
      end else if (r_state == ST_REQ && bus.bus_ack && !r_we) begin
         r_rdata <= w_load;
      end
   end

   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);
   assign rdata         = r_rdata;
   assign addr_err      = r_addr_err;
   assign bus.bus_req   = (r_state == ST_REQ);
   assign bus.bus_we    = r_we;
   assign bus.bus_addr  = {r_word, 2'b00};
   assign bus.bus_be    = r_be;
   assign bus.bus_wdata = r_wdata;

endmodule
`default_nettype wire
